tx_bit_timer: RTL and testbench

TX_BIT_TIMER -- requirements
Module: tx_bit_timer

---
 rtl/tx_bit_timer.sv | 101 ++++++++++
 tb/tb_tx_bit_timer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/tx_bit_timer.sv
// Bit/byte period timer for a serial transmitter; TX_TIMER_BIT_STUFF_EN compiles in stuffed-bit insertion.
// Strobes are decoded from registered counters; timer_en stalls the cycle counter, load_data restarts a byte.
module tx_bit_timer #(
    parameter int CLKS_PER_BIT  = 8,
    parameter int BITS_PER_BYTE = 8,
    parameter int WARN_BITS     = 1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic timer_en,
    input  logic load_data,
    input  logic stuff_req,
    output logic shift_en,
    output logic byte_done,
    output logic byte_warn,
    output logic stuff_slot,
    output logic busy
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = $clog2(BITS_PER_BYTE + 1);
    localparam logic [CW-1:0] CNT_TERM = CW'(CLKS_PER_BIT);
    localparam logic [BW-1:0] BIT_TERM = BW'(BITS_PER_BYTE);
    localparam logic [BW-1:0] WARN_IDX = BW'(BITS_PER_BYTE - WARN_BITS);

    typedef enum logic [1:0] {IDLE, RUN, STUFF} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_count, w_count_nxt;
    logic [BW-1:0] r_bitcnt, w_bitcnt_nxt;
    logic          w_cnt_term;
    logic          w_stuff_go;

    assign w_cnt_term = (r_state != IDLE) && (r_count == CNT_TERM);
    assign busy       = (r_state != IDLE);
    assign shift_en   = (r_state == RUN) && w_cnt_term;
    assign byte_done  = busy && (r_bitcnt == BIT_TERM);
    assign byte_warn  = busy && (r_bitcnt == WARN_IDX);

`ifdef TX_TIMER_BIT_STUFF_EN
    assign stuff_slot = (r_state == STUFF);
    assign w_stuff_go = shift_en && stuff_req && !load_data;
`else
    logic w_unused_stuff;
    assign w_unused_stuff = stuff_req;
    assign stuff_slot     = 1'b0;
    assign w_stuff_go     = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_bitcnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_bitcnt <= w_bitcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_bitcnt_nxt = r_bitcnt;
        if (load_data) begin
            w_state_nxt  = RUN;
            w_count_nxt  = CW'(1);
            w_bitcnt_nxt = '0;
        end else begin
            case (r_state)
                RUN, STUFF: begin
                    if (w_cnt_term) begin
                        w_count_nxt = CW'(1);
                    end else if (timer_en) begin
                        w_count_nxt = r_count + CW'(1);
                    end
                    // byte_done and shift_en never coincide: the byte ends one cycle after the last shift.
                    if (byte_done) begin
                        w_bitcnt_nxt = '0;
                    end else if (shift_en) begin
                        w_bitcnt_nxt = r_bitcnt + BW'(1);
                    end
                    if (w_stuff_go) begin
                        w_state_nxt = STUFF;
                    end else if (byte_done && !timer_en) begin
                        w_state_nxt  = IDLE;
                        w_count_nxt  = '0;
                        w_bitcnt_nxt = '0;
                    end else if ((r_state == STUFF) && w_cnt_term) begin
                        w_state_nxt = RUN;
                    end
                end
                default: begin
                    w_state_nxt  = IDLE;
                    w_count_nxt  = '0;
                    w_bitcnt_nxt = '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tx_bit_timer.sv
// Directed bench for tx_bit_timer: default 8/8/1 instance plus a 4/10/3 instance.
module tb_tx_bit_timer;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic timer_en = 1'b1, load_data = 1'b0, stuff_req = 1'b0;
    logic shift_en, byte_done, byte_warn, stuff_slot, busy;
    logic ten1 = 1'b1, ld1 = 1'b0, sr1 = 1'b0;
    logic sh1, dn1, wn1, sl1, bz1;
    logic [4:0] v0, v1;
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    tx_bit_timer dut0 (
        .clk(clk), .n_rst(n_rst), .timer_en(timer_en), .load_data(load_data),
        .stuff_req(stuff_req), .shift_en(shift_en), .byte_done(byte_done),
        .byte_warn(byte_warn), .stuff_slot(stuff_slot), .busy(busy)
    );

    tx_bit_timer #(.CLKS_PER_BIT(4), .BITS_PER_BYTE(10), .WARN_BITS(3)) dut1 (
        .clk(clk), .n_rst(n_rst), .timer_en(ten1), .load_data(ld1),
        .stuff_req(sr1), .shift_en(sh1), .byte_done(dn1),
        .byte_warn(wn1), .stuff_slot(sl1), .busy(bz1)
    );

    // Output vectors are {shift_en, byte_done, byte_warn, stuff_slot, busy}.
    assign v0 = {shift_en, byte_done, byte_warn, stuff_slot, busy};
    assign v1 = {sh1, dn1, wn1, sl1, bz1};

    task automatic check_eq(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%b exp=%b", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        load_data = 1'b0; stuff_req = 1'b0; timer_en = 1'b1;
        ld1 = 1'b0; ten1 = 1'b1;
        tick();
        check_eq("rst_dut0", v0, 5'b00000);
        check_eq("rst_dut1", v1, 5'b00000);
        n_rst = 1'b1;
        tick();
    endtask

    function automatic logic [4:0] exp_s1(input int e);
        exp_s1 = {(e % 8 == 7), (e == 64), (e >= 56 && e <= 63), 1'b0, 1'b1};
    endfunction

    function automatic logic [4:0] exp_s2(input int e);
        exp_s2 = {(e % 8 == 7) && (e != 31), (e == 72), (e >= 64 && e <= 71),
                  (e >= 24 && e <= 31), 1'b1};
    endfunction

    function automatic logic [4:0] exp_s3(input int e);
        exp_s3 = {(e == 7) || (e >= 20 && (e - 20) % 8 == 0), (e == 69),
                  (e >= 61 && e <= 68), 1'b0, 1'b1};
    endfunction

    function automatic logic [4:0] exp_s4(input int e);
        logic slot;
        slot = 1'b0;
`ifdef TX_TIMER_BIT_STUFF_EN
        slot = (e >= 24 && e <= 29);
`endif
        exp_s4 = {(e < 30 && e % 8 == 7) || (e == 37), 1'b0, 1'b0, slot, 1'b1};
    endfunction

    function automatic logic [4:0] exp_s5(input int e);
        exp_s5 = {(e % 4 == 3), (e == 40), (e >= 28 && e <= 31), 1'b0, 1'b1};
    endfunction

    initial begin
        // Single byte, continuous enable.
        do_reset();
        load_data = 1'b1; tick(); load_data = 1'b0;
        check_eq("s1_e0", v0, exp_s1(0));
        for (int e = 1; e <= 66; e++) begin
            tick();
            check_eq($sformatf("s1_e%0d", e), v0, exp_s1(e));
        end

        // Stuff request during the third shift_en cycle.
        do_reset();
        load_data = 1'b1; tick(); load_data = 1'b0;
        for (int e = 1; e <= 74; e++) begin
            stuff_req = (e == 24);
            tick();
`ifdef TX_TIMER_BIT_STUFF_EN
            check_eq($sformatf("s2_e%0d", e), v0, exp_s2(e));
`else
            check_eq($sformatf("s2_e%0d", e), v0, exp_s1(e));
`endif
        end
        stuff_req = 1'b0;

        // Enable gap of five edges, then idle on byte_done.
        do_reset();
        load_data = 1'b1; tick(); load_data = 1'b0;
        for (int e = 1; e <= 69; e++) begin
            timer_en = !(e >= 10 && e <= 14);
            tick();
            check_eq($sformatf("s3_e%0d", e), v0, exp_s3(e));
        end
        timer_en = 1'b0;
        tick();
        check_eq("s3_idle_e70", v0, 5'b00000);
        tick();
        check_eq("s3_idle_e71", v0, 5'b00000);
        timer_en = 1'b1;

        // Reload mid-byte (inside the stuff slot when compiled in), then async reset.
        do_reset();
        load_data = 1'b1; tick(); load_data = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            stuff_req = (e == 24);
            load_data = (e == 30);
            tick();
            check_eq($sformatf("s4_e%0d", e), v0, exp_s4(e));
        end
        stuff_req = 1'b0; load_data = 1'b0;
        #2 n_rst = 1'b0;
        #1 check_eq("s4_async_rst", v0, 5'b00000);
        tick();
        check_eq("s4_rst_held", v0, 5'b00000);
        n_rst = 1'b1;
        for (int e = 0; e < 12; e++) begin
            tick();
            check_eq($sformatf("s4_post_rst%0d", e), v0, 5'b00000);
        end

        // 4/10/3 instance; stuff_req held high where the feature is compiled out.
        do_reset();
`ifndef TX_TIMER_BIT_STUFF_EN
        sr1 = 1'b1;
`endif
        ld1 = 1'b1; tick(); ld1 = 1'b0;
        check_eq("s5_e0", v1, exp_s5(0));
        for (int e = 1; e <= 42; e++) begin
            tick();
            check_eq($sformatf("s5_e%0d", e), v1, exp_s5(e));
        end
        sr1 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
